// File: rtl/mux_8to1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_8to1_rr_sched
//   Round-robin scheduler in front of one shared 8-to-1 mux. Each grant
//   captures the winning requester's data bit and offers it downstream on a
//   valid/ready port. A stall watchdog drops a transfer that the consumer
//   refuses for too long.
//
//   Parameters
//     N        number of requesters (fixed at 8, the mux width)
//     SW       select width
//     TIMEOUT  stall cycles tolerated before a drop; 0 disables the watchdog
//
//   Ports
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     req      in   request vector, req[k] from requester k
//     i        in   mux data inputs, i[k] belongs to requester k
//     y_ready  in   consumer accepts y this cycle
//     y        out  captured mux output i[s]
//     y_valid  out  y is valid
//     s        out  mux select / index of the granted requester
//     gnt      out  one-hot grant; gnt[k] & y_valid & y_ready = accept for k
//     err      out  one-cycle pulse when the watchdog drops a transfer
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | nothing offered; arbitrate as soon as any request is pending
//   XFER   | s/gnt/y held stable and offered until handshake or watchdog drop
// -----------------------------------------------------------------------------
module mux_8to1_rr_sched #(
  parameter int N       = 8,
  parameter int SW      = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  i,
  input  logic          y_ready,
  output logic          y,
  output logic          y_valid,
  output logic [SW-1:0] s,
  output logic [N-1:0]  gnt,
  output logic          err
);

  // Counter must be able to hold TIMEOUT itself; keep at least one bit so
  // the TIMEOUT=0 build still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q,   ptr_d;
  logic [SW-1:0]   s_q,     s_d;
  logic [N-1:0]    gnt_q,   gnt_d;
  logic            y_q,     y_d;
  logic            yv_q,    yv_d;
  logic            err_q,   err_d;
  logic [CW-1:0]   stall_q, stall_d;

  logic            hs;
  logic [N-1:0]    req_masked;
  logic [SW-1:0]   ptr_next;
  logic [SW:0]     pick_idle;
  logic [SW:0]     pick_b2b;

  // Returns {found, index}: first set bit of v at or after p, wrapping past
  // N-1 back to 0. Scanning offsets from the far end down lets the closest
  // offset overwrite earlier hits, so no priority chain needs unrolling.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0]  v,
                                          input logic [SW-1:0] p);
    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] k;
    found = 1'b0;
    idx   = '0;
    for (int o = N - 1; o >= 0; o--) begin
      k = p + SW'(o);
      if (v[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  assign hs         = yv_q & y_ready;
  assign ptr_next   = s_q + SW'(1);
  // The current winner is excluded so a back-to-back grant always moves on;
  // a requester that keeps its request up is picked again from IDLE later.
  assign req_masked = req & ~gnt_q;
  assign pick_idle  = rr_pick(req, ptr_q);
  assign pick_b2b   = rr_pick(req_masked, ptr_next);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    yv_d    = yv_q;
    err_d   = 1'b0;
    stall_d = stall_q;

    case (state_q)
      S_IDLE: begin
        if (pick_idle[SW]) begin
          s_d     = pick_idle[SW-1:0];
          gnt_d   = ONE_N << pick_idle[SW-1:0];
          y_d     = i[pick_idle[SW-1:0]];
          yv_d    = 1'b1;
          stall_d = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (hs) begin
          ptr_d   = ptr_next;
          stall_d = '0;
          if (pick_b2b[SW]) begin
            s_d   = pick_b2b[SW-1:0];
            gnt_d = ONE_N << pick_b2b[SW-1:0];
            y_d   = i[pick_b2b[SW-1:0]];
            yv_d  = 1'b1;
          end else begin
            gnt_d   = '0;
            yv_d    = 1'b0;
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT > 0) && (stall_q == TO_CNT)) begin
          // Drop: no accept pulse is possible because gnt and y_valid
          // clear together.
          err_d   = 1'b1;
          ptr_d   = ptr_next;
          gnt_d   = '0;
          yv_d    = 1'b0;
          stall_d = '0;
          state_d = S_IDLE;
        end else if (TIMEOUT > 0) begin
          stall_d = stall_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        yv_d    = 1'b0;
        stall_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      s_q     <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign y       = y_q;
  assign y_valid = yv_q;
  assign s       = s_q;
  assign gnt     = gnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mux_8to1_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_8to1_rr_sched
//   Directed bench for mux_8to1_rr_sched with hand-computed expectations:
//   reset, single grant, full rotation, stall, watchdog drop, handshake vs
//   timeout race, pointer wrap and asynchronous reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_mux_8to1_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] i;
  logic       y_ready;
  logic       y;
  logic       y_valid;
  logic [2:0] s;
  logic [7:0] gnt;
  logic       err;

  int n_chk;
  int n_fail;

  mux_8to1_rr_sched #(
    .N       (8),
    .SW      (3),
    .TIMEOUT (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .i       (i),
    .y_ready (y_ready),
    .y       (y),
    .y_valid (y_valid),
    .s       (s),
    .gnt     (gnt),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_yv"},  32'(y_valid), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt),     32'd0);
    chk({tag, "_s"},   32'(s),       32'd0);
    chk({tag, "_y"},   32'(y),       32'd0);
    chk({tag, "_err"}, 32'(err),     32'd0);
  endtask

  initial begin
    int acc;
    int lat;
    bit seen;

    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 8'hFF;
    i       = 8'h00;
    y_ready = 1'b0;

    // T1 reset, then first grant goes to 0
    step();
    step();
    chk_idle_zero("t1_rst");
    i       = 8'h01;
    y_ready = 1'b1;
    rst_n   = 1'b1;
    step();
    chk("t1_s",   32'(s),       32'd0);
    chk("t1_gnt", 32'(gnt),     32'h01);
    chk("t1_y",   32'(y),       32'd1);
    chk("t1_yv",  32'(y_valid), 32'd1);
    req = 8'h00;
    step();
    chk("t1_idle_yv",  32'(y_valid), 32'd0);
    chk("t1_idle_gnt", 32'(gnt),     32'd0);

    // T2 single requester 5
    req = 8'h20;
    i   = 8'h20;
    step();
    chk("t2_s",   32'(s),       32'd5);
    chk("t2_gnt", 32'(gnt),     32'h20);
    chk("t2_y",   32'(y),       32'd1);
    chk("t2_yv",  32'(y_valid), 32'd1);
    req = 8'h00;
    step();
    chk("t2_idle_yv", 32'(y_valid), 32'd0);

    // T3 rotation from ptr=0
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    req     = 8'hFF;
    i       = 8'h55;
    y_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t3_s",   32'(s),       32'(k % 8));
      chk("t3_gnt", 32'(gnt),     32'(1 << (k % 8)));
      chk("t3_y",   32'(y),       32'(((k % 8) % 2) == 0));
      chk("t3_yv",  32'(y_valid), 32'd1);
    end
    req = 8'h00;
    step();
    chk("t3_end_yv", 32'(y_valid), 32'd0);

    // T4 stall three cycles, then accept once (ptr=1)
    acc     = 0;
    req     = 8'h02;
    i       = 8'h02;
    y_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t4_s",   32'(s),       32'd1);
      chk("t4_gnt", 32'(gnt),     32'h02);
      chk("t4_y",   32'(y),       32'd1);
      chk("t4_yv",  32'(y_valid), 32'd1);
      req = 8'h00;
      i   = 8'h00;
      if (c == 3) y_ready = 1'b1;
      if (y_valid && y_ready && gnt[1]) acc++;
    end
    step();
    chk("t4_end_yv", 32'(y_valid), 32'd0);
    chk("t4_acc",    32'(acc),     32'd1);

    // T5 watchdog drop (ptr=2, winner 3)
    req     = 8'h08;
    y_ready = 1'b0;
    step();
    chk("t5_s", 32'(s), 32'd3);
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      step();
      if (err) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    chk("t5_err_seen", 32'(seen),    32'd1);
    chk("t5_err_lat",  32'(lat),     32'd17);
    chk("t5_drop_yv",  32'(y_valid), 32'd0);
    chk("t5_drop_gnt", 32'(gnt),     32'd0);
    req = 8'h18;
    step();
    chk("t5_err_pulse", 32'(err), 32'd0);
    chk("t5_ptr4_s",    32'(s),   32'd4);
    chk("t5_ptr4_gnt",  32'(gnt), 32'h10);
    req     = 8'h00;
    y_ready = 1'b1;
    step();
    chk("t5_end_yv", 32'(y_valid), 32'd0);

    // Handshake and timeout in the same cycle (ptr=5, winner 3)
    req     = 8'h08;
    y_ready = 1'b0;
    step();
    chk("race_s", 32'(s), 32'd3);
    req = 8'h00;
    repeat (16) step();
    chk("race_pre_err", 32'(err),     32'd0);
    chk("race_pre_yv",  32'(y_valid), 32'd1);
    y_ready = 1'b1;
    step();
    chk("race_err", 32'(err),     32'd0);
    chk("race_yv",  32'(y_valid), 32'd0);
    step();
    chk("race_err2", 32'(err), 32'd0);

    // Pointer wrap: bring ptr to 7, then req=0x81 gives 7 then 0
    req = 8'h40;
    step();
    chk("wrap_pre_s", 32'(s), 32'd6);
    req = 8'h00;
    step();
    req = 8'h81;
    step();
    chk("wrap_s7", 32'(s), 32'd7);
    req = 8'h01;
    step();
    chk("wrap_s0",  32'(s),       32'd0);
    chk("wrap_yv",  32'(y_valid), 32'd1);
    req = 8'h00;
    step();
    chk("wrap_end_yv", 32'(y_valid), 32'd0);

    // T6 async reset mid-transfer (ptr=1, winner 4)
    req     = 8'h10;
    i       = 8'h10;
    y_ready = 1'b0;
    step();
    chk("t6_s",  32'(s),       32'd4);
    chk("t6_yv", 32'(y_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("t6_async");
    req     = 8'hFF;
    i       = 8'h00;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_restart_s",   32'(s),   32'd0);
    chk("t6_restart_gnt", 32'(gnt), 32'h01);
    req = 8'h00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
